usb_ep_scheduler: RTL and testbench

- Per-transaction sequencer between the `usb` core and up to NUM_EP endpoint byte buffers.
- Latches endpoint, direction and setup at each token, then decides handshake and data_toggle.
- Streams IN bytes (ep_rd) or OUT bytes (ep_wr) to the selected buffer and reports completion so the buffer can commit or rewind.
- Owns per-endpoint toggle and stall state. Replaces hand-coded EP0 sequencing in the top level.

---
 rtl/usb_pkg.sv | 20 ++
 rtl/usb_ep_state.sv | 39 +++
 rtl/usb_ep_scheduler.sv | 168 ++++++++++++++++
 tb/tb_usb_ep_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared encodings for the USB endpoint scheduler: handshake codes, FSM states, endpoint index width.
package usb_pkg;
  localparam int EP_W = 4;

  typedef enum logic [1:0] {
    HS_ACK   = 2'b00,
    HS_NONE  = 2'b01,
    HS_NAK   = 2'b10,
    HS_STALL = 2'b11
  } hs_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_IN_DATA,
    ST_OUT_DATA,
    ST_WAIT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/usb_ep_state.sv
// Per-endpoint data-toggle and stall register file; toggle read at idx, stall exported as a vector.
module usb_ep_state
  import usb_pkg::*;
#(
  parameter int NUM_EP = 4
) (
  input  logic              clk,
  input  logic              clr_all,
  input  logic [EP_W-1:0]   idx,
  input  logic              tgl_flip,
  input  logic              tgl_force,
  input  logic              stall_clr,
  input  logic [NUM_EP-1:0] stall_set,
  output logic              tgl,
  output logic [NUM_EP-1:0] stall
);
  logic [NUM_EP-1:0] tgl_q;
  logic [15:0]       tgl_pad;

  assign tgl_pad = 16'(tgl_q);
  assign tgl     = tgl_pad[idx];

  always_ff @(posedge clk) begin
    if (clr_all) begin
      tgl_q <= '0;
      stall <= '0;
    end else begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (EP_W'(i) == idx) begin
          if (tgl_force)     tgl_q[i] <= 1'b1;
          else if (tgl_flip) tgl_q[i] <= ~tgl_q[i];
          if (stall_clr)     stall[i] <= 1'b0;
        end
        // a set arriving with a SETUP clear on the same endpoint wins
        if (stall_set[i]) stall[i] <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/usb_ep_scheduler.sv
// Per-transaction endpoint sequencer: latches token, decides handshake/toggle, streams bytes, reports completion.
// Optional transaction watchdog enabled by USB_EP_TIMEOUT_EN.
module usb_ep_scheduler
  import usb_pkg::*;
#(
  parameter int NUM_EP      = 4,
  parameter int MAX_PKT     = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                usb_rst,
  input  logic                transaction_active,
  input  logic [EP_W-1:0]     endpoint,
  input  logic                direction_in,
  input  logic                setup,
  input  logic                success,
  input  logic                data_strobe,
  output logic [1:0]          handshake,
  output logic                data_toggle,
  output logic                data_in_valid,
  input  logic [NUM_EP-1:0]   ep_enable,
  input  logic [NUM_EP-1:0]   ep_stall_set,
  input  logic [8*NUM_EP-1:0] ep_in_avail,
  input  logic [8*NUM_EP-1:0] ep_out_free,
  output logic [NUM_EP-1:0]   ep_sel,
  output logic                ep_rd,
  output logic                ep_wr,
  output logic                ep_done,
  output logic                ep_done_ok,
  output logic [7:0]          ep_done_len,
  output logic                ep_done_setup,
  output logic [NUM_EP-1:0]   ep_stalled,
  output logic                timeout_err
);
  localparam logic [7:0] MAX_PKT_B = 8'(MAX_PKT);

  state_t          state;
  logic            armed, dir_q, setup_q;
  logic [EP_W-1:0] idx;
  logic [7:0]      limit, cnt, avail, free;
  logic [15:0]     en_pad, stall_pad, sel_pad;
  logic [127:0]    avail_pad, free_pad;
  logic            clr_all, ep_on, in_ack, tgl_cur, active, end_xfer, end_ok, tmo_hit;

  assign clr_all   = !rst || usb_rst;
  assign en_pad    = 16'(ep_enable) | 16'd1;  // EP0 is always enabled
  assign stall_pad = 16'(ep_stalled);
  assign sel_pad   = 16'd1 << idx;
  assign avail_pad = 128'(ep_in_avail);
  assign free_pad  = 128'(ep_out_free);
  assign avail     = avail_pad[{idx, 3'b000} +: 8];
  assign free      = free_pad[{idx, 3'b000} +: 8];
  assign ep_on     = ({1'b0, idx} < 5'(NUM_EP)) && en_pad[idx];
  assign in_ack    = ep_on && !setup_q && dir_q && !stall_pad[idx] && (avail != 8'd0);
  assign active    = (state == ST_IN_DATA) || (state == ST_OUT_DATA) || (state == ST_WAIT);
  assign end_xfer  = active && !transaction_active;
  assign end_ok    = end_xfer && success && (handshake == HS_ACK);

`ifdef USB_EP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd;

  always_ff @(posedge clk) begin
    if (clr_all || !(active || state == ST_DECIDE)) wd <= '0;
    else                                            wd <= wd + 1'b1;
  end
  assign tmo_hit = (active || state == ST_DECIDE) && (wd == TW'(TIMEOUT_CYC - 1)) && !end_xfer;
`else
  assign tmo_hit = 1'b0;
`endif

  usb_ep_state #(.NUM_EP(NUM_EP)) u_state (
    .clk       (clk),
    .clr_all   (clr_all),
    .idx       (idx),
    .tgl_flip  (end_ok),
    .tgl_force (end_ok && setup_q),
    .stall_clr (state == ST_DECIDE && setup_q && ep_on),
    .stall_set (ep_stall_set),
    .tgl       (tgl_cur),
    .stall     (ep_stalled)
  );

  always_ff @(posedge clk) begin
    if (clr_all) begin
      state         <= ST_IDLE;
      armed         <= 1'b0;
      idx           <= '0;
      dir_q         <= 1'b0;
      setup_q       <= 1'b0;
      limit         <= '0;
      cnt           <= '0;
      handshake     <= HS_NONE;
      data_toggle   <= 1'b0;
      data_in_valid <= 1'b0;
      ep_sel        <= '0;
      ep_rd         <= 1'b0;
      ep_wr         <= 1'b0;
      ep_done       <= 1'b0;
      ep_done_ok    <= 1'b0;
      ep_done_len   <= '0;
      ep_done_setup <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      // a token is only accepted once transaction_active has been seen low
      armed       <= armed || !transaction_active;
      ep_rd       <= 1'b0;
      ep_wr       <= 1'b0;
      ep_done     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: if (transaction_active && armed) begin
          armed   <= 1'b0;
          idx     <= endpoint;
          dir_q   <= direction_in;
          setup_q <= setup;
          cnt     <= '0;
          state   <= ST_DECIDE;
        end
        ST_DECIDE: begin
          data_toggle   <= setup_q ? 1'b0 : tgl_cur;
          limit         <= (avail < MAX_PKT_B) ? avail : MAX_PKT_B;
          ep_sel        <= ep_on ? sel_pad[NUM_EP-1:0] : '0;
          data_in_valid <= in_ack;
          if (!ep_on) begin
            handshake <= HS_NONE;
            state     <= ST_WAIT;
          end else if (setup_q) begin
            handshake <= HS_ACK;
            state     <= ST_OUT_DATA;
          end else begin
            if (stall_pad[idx])                                    handshake <= HS_STALL;
            else if (dir_q ? (avail == 8'd0) : (free < MAX_PKT_B)) handshake <= HS_NAK;
            else                                                   handshake <= HS_ACK;
            state <= dir_q ? ST_IN_DATA : ST_OUT_DATA;
          end
        end
        ST_IN_DATA: if (data_strobe && handshake == HS_ACK && cnt < limit) begin
          ep_rd         <= 1'b1;
          cnt           <= cnt + 8'd1;
          data_in_valid <= (cnt + 8'd1) < limit;
        end
        ST_OUT_DATA: if (data_strobe && handshake == HS_ACK) begin
          ep_wr <= 1'b1;
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        end
        ST_WAIT: ;
        ST_DONE: begin
          state       <= ST_IDLE;
          handshake   <= HS_NONE;
          data_toggle <= 1'b0;
          ep_sel      <= '0;
        end
        default: state <= ST_IDLE;
      endcase
      if (end_xfer || tmo_hit) begin
        state         <= ST_DONE;
        ep_done       <= 1'b1;
        ep_done_ok    <= end_ok;
        ep_done_len   <= cnt;
        ep_done_setup <= setup_q;
        data_in_valid <= 1'b0;
        timeout_err   <= tmo_hit;
      end
    end
  end
endmodule

// File: tb/tb_usb_ep_scheduler.sv
// Randomized self-checking bench for usb_ep_scheduler against a transaction-level reference model.
`timescale 1ns/1ps
module tb_usb_ep_scheduler;
  import usb_pkg::*;
  localparam int NEP  = 4;
  localparam int MPKT = 64;

  logic             clk = 0, rst = 0, usb_rst = 0, transaction_active = 0;
  logic             direction_in = 0, setup = 0, success = 0, data_strobe = 0;
  logic [3:0]       endpoint = 0;
  logic [1:0]       handshake;
  logic             data_toggle, data_in_valid, ep_rd, ep_wr, ep_done, ep_done_ok, ep_done_setup, timeout_err;
  logic [7:0]       ep_done_len;
  logic [NEP-1:0]   ep_enable, ep_sel, ep_stalled;
  logic [NEP-1:0]   ep_stall_set = 0;
  logic [8*NEP-1:0] ep_in_avail, ep_out_free;

  int avail_m[NEP], free_m[NEP];
  bit en_m[NEP], tgl_m[NEP], stall_m[NEP];
  int checks = 0, passed = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, tmo_cnt = 0;
  bit last_ok, last_setup;
  logic [7:0] last_len;

  typedef struct packed {
    logic [1:0] hs; logic tg; logic [3:0] sel; logic dv; logic [7:0] rd; logic [7:0] wr;
    logic [3:0] dones; logic ok; logic [7:0] len; logic stp;
  } res_t;

  usb_ep_scheduler #(.NUM_EP(NEP), .MAX_PKT(MPKT), .TIMEOUT_CYC(4096)) dut (
    .clk(clk), .rst(rst), .usb_rst(usb_rst), .transaction_active(transaction_active),
    .endpoint(endpoint), .direction_in(direction_in), .setup(setup), .success(success),
    .data_strobe(data_strobe), .handshake(handshake), .data_toggle(data_toggle),
    .data_in_valid(data_in_valid), .ep_enable(ep_enable), .ep_stall_set(ep_stall_set),
    .ep_in_avail(ep_in_avail), .ep_out_free(ep_out_free), .ep_sel(ep_sel), .ep_rd(ep_rd),
    .ep_wr(ep_wr), .ep_done(ep_done), .ep_done_ok(ep_done_ok), .ep_done_len(ep_done_len),
    .ep_done_setup(ep_done_setup), .ep_stalled(ep_stalled), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    ep_in_avail = '0;
    ep_out_free = '0;
    ep_enable   = '0;
    for (int i = 0; i < NEP; i++) begin
      ep_in_avail[8*i +: 8] = 8'(avail_m[i]);
      ep_out_free[8*i +: 8] = 8'(free_m[i]);
      ep_enable[i]          = en_m[i];
    end
  end

  always @(negedge clk) begin
    if (ep_rd) rd_cnt++;
    if (ep_wr) wr_cnt++;
    if (timeout_err) tmo_cnt++;
    if (ep_done) begin
      done_cnt++;
      last_ok    = ep_done_ok;
      last_len   = ep_done_len;
      last_setup = ep_done_setup;
    end
  end

  function automatic string show(res_t r);
    return $sformatf("hs=%b tg=%b sel=%b dv=%b rd=%0d wr=%0d done=%0d ok=%b len=%0d setup=%b",
                     r.hs, r.tg, r.sel, r.dv, r.rd, r.wr, r.dones, r.ok, r.len, r.stp);
  endfunction

  function automatic logic [25:0] out_vec();
    return {handshake, data_toggle, data_in_valid, ep_sel, ep_rd, ep_wr, ep_done, ep_done_ok,
            ep_done_len, ep_done_setup, ep_stalled, timeout_err};
  endfunction

  function automatic logic [NEP-1:0] stall_vec();
    logic [NEP-1:0] v;
    for (int i = 0; i < NEP; i++) v[i] = stall_m[i];
    return v;
  endfunction

  // Reference: what one complete token should produce, plus the endpoint state it leaves behind.
  task automatic predict(input int ep, input bit din, input bit stp, input int nstb, input bit succ,
                         output res_t e);
    bit valid;
    int lim, mv;
    valid = (ep < NEP) && (ep == 0 || en_m[ep]);
    e = '0;
    e.stp = stp;
    e.dones = 1;
    if (!valid)                          e.hs = HS_NONE;
    else if (stp)                        e.hs = HS_ACK;
    else if (stall_m[ep])                e.hs = HS_STALL;
    else if (din && avail_m[ep] == 0)    e.hs = HS_NAK;
    else if (!din && free_m[ep] < MPKT)  e.hs = HS_NAK;
    else                                 e.hs = HS_ACK;
    e.sel = valid ? 4'(1 << ep) : 4'd0;
    e.tg  = (valid && !stp) ? tgl_m[ep] : 1'b0;
    if (e.hs == HS_ACK) begin
      if (din && !stp) begin
        lim  = (avail_m[ep] < MPKT) ? avail_m[ep] : MPKT;
        mv   = (nstb < lim) ? nstb : lim;
        e.rd = 8'(mv);
        e.dv = (mv < lim);
      end else begin
        mv   = (nstb > 255) ? 255 : nstb;
        e.wr = 8'(nstb);
      end
      e.len = 8'(mv);
    end
    e.ok = succ && (e.hs == HS_ACK);
    if (valid && stp) stall_m[ep] = 0;
    if (e.ok) tgl_m[ep] = stp ? 1'b1 : !tgl_m[ep];
  endtask

  task automatic run_xfer(input int ep, input bit din, input bit stp, input int nstb, input bit succ,
                          output res_t r);
    int rd0, wr0, dn0, k;
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    r = '0;
    @(posedge clk); #1;
    endpoint = 4'(ep); direction_in = din; setup = stp; transaction_active = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    r.hs = handshake; r.tg = data_toggle; r.sel = ep_sel;
    if (nstb > 0) begin
      @(posedge clk); #1 data_strobe = 1;
      repeat (nstb) @(posedge clk);
      #1 data_strobe = 0;
    end
    @(negedge clk);
    r.dv = data_in_valid;
    @(posedge clk); #1 success = succ; transaction_active = 0;
    k = 0;
    while (done_cnt == dn0 && k < 8) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (r.hs == HS_NONE) r.tg = 1'b0;
    r.rd = 8'(rd_cnt - rd0); r.wr = 8'(wr_cnt - wr0); r.dones = 4'(done_cnt - dn0);
    r.ok = last_ok; r.len = last_len; r.stp = last_setup;
  endtask

  task automatic test_reset();
    logic [25:0] got;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = out_vec();
    checks++;
    if (got !== {2'b01, 24'd0}) $display("FAIL reset_outputs: got %h want %h", got, {2'b01, 24'd0});
    else passed++;
    for (int i = 0; i < NEP; i++) begin
      avail_m[i] = 0; free_m[i] = 100; en_m[i] = 1; tgl_m[i] = 0; stall_m[i] = 0;
    end
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_setup_ep0();
    res_t r, e;
    predict(0, 0, 1, 8, 1, e); run_xfer(0, 0, 1, 8, 1, r);
    checks++;
    if (r !== e) $display("FAIL setup_ep0: got %s want %s", show(r), show(e)); else passed++;
    predict(0, 0, 0, 2, 0, e); run_xfer(0, 0, 0, 2, 0, r);
    checks++;
    if (r !== e) $display("FAIL ep0_toggle_after_setup: got %s want %s", show(r), show(e)); else passed++;
  endtask

  task automatic test_in_max();
    res_t r, e;
    avail_m[1] = 100;
    predict(1, 1, 0, 70, 1, e); run_xfer(1, 1, 0, 70, 1, r);
    checks++;
    if (r !== e) $display("FAIL in_max_pkt: got %s want %s", show(r), show(e)); else passed++;
    checks++;
    if (r.len !== 8'd64 || r.rd !== 8'd64) $display("FAIL in_max_len: got len=%0d rd=%0d want 64", r.len, r.rd);
    else passed++;
  endtask

  task automatic test_in_nak();
    res_t r, e;
    avail_m[1] = 0;
    predict(1, 1, 0, 3, 1, e); run_xfer(1, 1, 0, 3, 1, r);
    checks++;
    if (r !== e) $display("FAIL in_nak: got %s want %s", show(r), show(e)); else passed++;
    avail_m[1] = 10;
    predict(1, 1, 0, 2, 0, e); run_xfer(1, 1, 0, 2, 0, r);
    checks++;
    if (r !== e) $display("FAIL toggle_after_nak: got %s want %s", show(r), show(e)); else passed++;
  endtask

  task automatic test_stall();
    res_t r, e;
    en_m[2] = 1; free_m[2] = 100;
    @(posedge clk); #1 ep_stall_set = 4'b0100;
    @(posedge clk); #1 ep_stall_set = 4'b0000;
    stall_m[2] = 1;
    @(negedge clk);
    checks++;
    if (ep_stalled !== stall_vec()) $display("FAIL stall_set: got %b want %b", ep_stalled, stall_vec());
    else passed++;
    predict(2, 0, 0, 3, 1, e); run_xfer(2, 0, 0, 3, 1, r);
    checks++;
    if (r !== e) $display("FAIL out_stalled: got %s want %s", show(r), show(e)); else passed++;
    predict(2, 0, 1, 8, 1, e); run_xfer(2, 0, 1, 8, 1, r);
    checks++;
    if (r !== e) $display("FAIL setup_clears_stall: got %s want %s", show(r), show(e)); else passed++;
    checks++;
    if (ep_stalled !== stall_vec()) $display("FAIL stall_cleared: got %b want %b", ep_stalled, stall_vec());
    else passed++;
  endtask

  task automatic test_fail_and_bad_ep();
    res_t r, e;
    avail_m[1] = 30;
    predict(1, 1, 0, 10, 0, e); run_xfer(1, 1, 0, 10, 0, r);
    checks++;
    if (r !== e) $display("FAIL in_rewind: got %s want %s", show(r), show(e)); else passed++;
    predict(7, 1, 0, 4, 1, e); run_xfer(7, 1, 0, 4, 1, r);
    checks++;
    if (r !== e) $display("FAIL bad_endpoint: got %s want %s", show(r), show(e)); else passed++;
  endtask

  task automatic test_usb_rst();
    res_t r, e;
    int dn0;
    logic [25:0] got;
    avail_m[1] = 20; en_m[1] = 1;
    @(posedge clk); #1 endpoint = 1; direction_in = 1; setup = 0; transaction_active = 1;
    repeat (3) @(posedge clk);
    #1 data_strobe = 1;
    repeat (5) @(posedge clk);
    #1 data_strobe = 0;
    dn0 = done_cnt;
    usb_rst = 1;
    @(posedge clk); #1 usb_rst = 0;
    @(negedge clk);
    got = out_vec();
    checks++;
    if (got !== {2'b01, 24'd0}) $display("FAIL usb_rst_outputs: got %h want %h", got, {2'b01, 24'd0});
    else passed++;
    @(posedge clk); #1 transaction_active = 0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - dn0 !== 0) $display("FAIL usb_rst_no_done: got %0d done pulses want 0", done_cnt - dn0);
    else passed++;
    for (int i = 0; i < NEP; i++) begin tgl_m[i] = 0; stall_m[i] = 0; end
    predict(1, 1, 0, 4, 1, e); run_xfer(1, 1, 0, 4, 1, r);
    checks++;
    if (r !== e) $display("FAIL usb_rst_ep1_toggle: got %s want %s", show(r), show(e)); else passed++;
    predict(0, 0, 0, 2, 1, e); run_xfer(0, 0, 0, 2, 1, r);
    checks++;
    if (r !== e) $display("FAIL usb_rst_ep0_toggle: got %s want %s", show(r), show(e)); else passed++;
  endtask

  task automatic test_random();
    res_t r, e;
    int ep, nstb, sep;
    bit din, stp, succ;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NEP; i++) begin
        avail_m[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 120);
        free_m[i]  = $urandom_range(0, 255);
        en_m[i]    = ($urandom_range(0, 4) != 0);
      end
      if ($urandom_range(0, 4) == 0) begin
        sep = $urandom_range(0, NEP - 1);
        @(posedge clk); #1 ep_stall_set = 4'(1 << sep);
        @(posedge clk); #1 ep_stall_set = 4'b0000;
        stall_m[sep] = 1;
      end
      ep   = $urandom_range(0, 7);
      stp  = ($urandom_range(0, 6) == 0);
      din  = stp ? 1'b0 : 1'($urandom_range(0, 1));
      nstb = $urandom_range(0, 80);
      succ = ($urandom_range(0, 3) != 0);
      predict(ep, din, stp, nstb, succ, e);
      run_xfer(ep, din, stp, nstb, succ, r);
      checks++;
      if (r !== e) $display("FAIL random_%0d ep=%0d in=%b setup=%b: got %s want %s",
                            n, ep, din, stp, show(r), show(e));
      else passed++;
    end
  endtask

`ifdef USB_EP_TIMEOUT_EN
  task automatic test_timeout();
    int dn0, to0;
    en_m[1] = 1; free_m[1] = 100;
    dn0 = done_cnt; to0 = tmo_cnt;
    @(posedge clk); #1 endpoint = 1; direction_in = 0; setup = 0; success = 1; transaction_active = 1;
    repeat (4100) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (tmo_cnt - to0 !== 1) $display("FAIL timeout_pulse: got %0d want 1", tmo_cnt - to0); else passed++;
    checks++;
    if (done_cnt - dn0 !== 1 || last_ok !== 1'b0)
      $display("FAIL timeout_done: got %0d pulses ok=%b want 1 ok=0", done_cnt - dn0, last_ok);
    else passed++;
    @(posedge clk); #1 transaction_active = 0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - dn0 !== 1) $display("FAIL timeout_ignore: got %0d pulses want 1", done_cnt - dn0);
    else passed++;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_setup_ep0();
    test_in_max();
    test_in_nak();
    test_stall();
    test_fail_and_bad_ep();
    test_usb_rst();
    test_random();
`ifdef USB_EP_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
